puf_soc_ctrl: RTL

// - Challenge/response sequencer for the PUF SoC. It accepts a parallel N_BIT challenge word from
//   the serial-in/parallel-out receiver and launches N_EVAL PUF evaluations with that challenge.
// - The R_BIT responses are combined by per-bit majority vote. The voted word goes to the TX

---
 rtl/puf_soc_pkg.sv | 5 +
 rtl/puf_soc_ctrl_vote.sv | 29 ++
 rtl/puf_soc_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/puf_soc_pkg.sv
// puf_soc_pkg: shared state encoding and width constants for the PUF SoC controller
package puf_soc_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT, XMIT} ctrl_state_t;
    localparam int RESP_CNT_W = 16;
endpackage

// File: rtl/puf_soc_ctrl_vote.sv
// puf_soc_vote: per-bit majority vote over N_EVAL response samples
module puf_soc_vote #(
    parameter int R_BIT  = 32,
    parameter int N_EVAL = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_en,
    input  logic [R_BIT-1:0] i_resp,
    output logic [R_BIT-1:0] o_maj
);
    localparam int CW = $clog2(N_EVAL + 1);
    localparam logic [CW-1:0] HALF = CW'(N_EVAL / 2);
    logic [CW-1:0] cnt_q [R_BIT];
    logic [CW-1:0] cnt_d [R_BIT];
    // accumulate ones per bit; the majority already folds in the sample being presented
    always_comb begin
        for (int b = 0; b < R_BIT; b++) begin
            cnt_d[b] = clr ? '0 : cnt_q[b] + CW'(add_en & i_resp[b]);
            o_maj[b] = (cnt_q[b] + CW'(i_resp[b])) > HALF;
        end
    end
    // vote counters, discarded on reset
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '{default: '0};
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/puf_soc_ctrl.sv
// puf_soc_ctrl: challenge/response sequencer with majority vote and per-evaluation timeout
module puf_soc_ctrl
    import puf_soc_pkg::*;
#(
    parameter int N_BIT       = 40,
    parameter int R_BIT       = 32,
    parameter int N_EVAL      = 5,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_sipo_valid,
    input  logic [N_BIT-1:0]      i_sipo_data,
    output logic                  o_sipo_ready,
    output logic [N_BIT-1:0]      o_puf_challenge,
    output logic                  o_puf_start,
    input  logic                  i_puf_done,
    input  logic [R_BIT-1:0]      i_puf_response,
    output logic                  o_tx_valid,
    output logic [R_BIT-1:0]      o_tx_data,
    input  logic                  i_tx_ready,
    input  logic                  i_clr_err,
    output logic                  o_busy,
    output logic                  o_err_timeout,
    output logic [RESP_CNT_W-1:0] o_resp_count
);
    localparam int EW = $clog2(N_EVAL + 1);
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [EW-1:0] E_LAST = EW'(N_EVAL - 1);

    if (N_EVAL < 1 || N_EVAL % 2 == 0) begin : g_bad_n_eval
        $error("N_EVAL must be odd and >= 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be >= 1");
    end

    ctrl_state_t           state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [EW-1:0]         eval_q, eval_d;
    logic [N_BIT-1:0]      chal_q, chal_d;
    logic [R_BIT-1:0]      tx_data_q, tx_data_d;
    logic                  err_q, err_d;
    logic [RESP_CNT_W-1:0] cnt_q, cnt_d;
    logic                  accept, done, expired;
    logic [R_BIT-1:0]      vote_maj;

    assign accept  = state_q == IDLE && i_sipo_valid;
    assign done    = state_q == WAIT && i_puf_done;
    assign expired = state_q == WAIT && !i_puf_done && timer_q == '0;

    assign o_sipo_ready    = state_q == IDLE;
    assign o_puf_start     = state_q == START;
    assign o_tx_valid      = state_q == XMIT;
    assign o_busy          = state_q != IDLE;
    assign o_puf_challenge = chal_q;
    assign o_tx_data       = tx_data_q;
    assign o_err_timeout   = err_q;
    assign o_resp_count    = cnt_q;

    puf_soc_vote #(.R_BIT(R_BIT), .N_EVAL(N_EVAL)) u_vote (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .add_en (done),
        .i_resp (i_puf_response),
        .o_maj  (vote_maj)
    );

    // sequencing: accept, launch, wait with timeout, deliver; a timeout set beats a same-cycle clear
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        eval_d    = eval_q;
        chal_d    = chal_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        err_d     = expired | (err_q & ~i_clr_err);
        case (state_q)
            IDLE: if (i_sipo_valid) begin
                chal_d  = i_sipo_data;
                eval_d  = '0;
                state_d = START;
            end
            START: begin
                timer_d = T_LOAD;
                state_d = WAIT;
            end
            WAIT: if (i_puf_done) begin
                eval_d    = eval_q + 1'b1;
                state_d   = eval_q == E_LAST ? XMIT : START;
                tx_data_d = eval_q == E_LAST ? vote_maj : tx_data_q;
            end else if (timer_q == '0) begin
                state_d = IDLE;
            end else begin
                timer_d = timer_q - 1'b1;
            end
            XMIT: if (i_tx_ready) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // controller registers; reset aborts any transaction and clears the error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            eval_q    <= '0;
            chal_q    <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            eval_q    <= eval_d;
            chal_q    <= chal_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule
